// File: rtl/liteeth_sram_pkt_ctrl.sv
// liteeth_sram_pkt_ctrl: store-and-forward RX packet buffer controller.
// MAC words are written through SRAM port 0 and committed per packet to a
// descriptor FIFO; committed packets are replayed through the registered
// read port 1 into a 2-entry skid buffer feeding a valid/ready stream.
// Packets that do not fit (or find the descriptor FIFO full) are dropped.
// Optional feature: define LITEETH_SRAM_CTRL_STATS_EN to add the
// drop_count / pkt_count statistics outputs.
module liteeth_sram_pkt_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 384,
    parameter int DESC_DEPTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    input  logic [31:0]           sink_data,
    input  logic                  sink_last,
    input  logic [3:0]            sink_be,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [31:0]           source_data,
    output logic                  source_last,
    output logic [3:0]            source_be,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [31:0]           sram_dout1,
`ifdef LITEETH_SRAM_CTRL_STATS_EN
    output logic [15:0]           drop_count,
    output logic [15:0]           pkt_count,
`endif
    output logic [ADDR_WIDTH:0]   level
);
    // Length / occupancy width: a packet may be exactly DEPTH words long.
    localparam int LW = ADDR_WIDTH + 1;
    localparam int DW = $clog2(DESC_DEPTH);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Write side state
    logic [ADDR_WIDTH-1:0] wr_cur, wr_commit, rd_ptr;
    logic                  full, drop;
    logic [LW-1:0]         pkt_len, used, free_w;
    logic                  accept, drop_now, wr_en, commit, rewind;

    // Descriptor FIFO; the entry of the packet being streamed stays
    // resident until its last word is accepted downstream.
    logic [LW-1:0]         desc_len [DESC_DEPTH];
    logic [3:0]            desc_be  [DESC_DEPTH];
    logic [DW-1:0]         desc_wr, desc_rd, take_idx;
    logic [DW:0]           desc_cnt;
    logic                  desc_full;

    // Read side state
    state_t                state, state_nxt;
    logic [LW-1:0]         remaining, rem_eff;
    logic [3:0]            act_be, be_eff, be_tag;
    logic                  take, issue, pop, last_accept;
    logic [1:0]            occ, skid_cnt;
    logic                  skid_head, skid_tail;
    logic                  vld_p0, last_p0;
    logic [3:0]            be_p0;
    logic [31:0]           skid_data_p1 [2];
    logic                  skid_last_p1 [2];
    logic [3:0]            skid_be_p1   [2];

    // Occupancy, accept/drop decisions and SRAM port 0 drive
    always_comb begin
        if (full)
            used = LW'(DEPTH);
        else if (wr_cur >= rd_ptr)
            used = {1'b0, wr_cur} - {1'b0, rd_ptr};
        else
            used = {1'b0, wr_cur} + LW'(DEPTH) - {1'b0, rd_ptr};
        free_w      = LW'(DEPTH) - used;
        sink_ready  = !sys_rst;
        accept      = sink_valid && sink_ready;
        drop_now    = drop || (free_w == '0);
        wr_en       = accept && !drop_now;
        desc_full   = (desc_cnt == (DW+1)'(DESC_DEPTH));
        commit      = accept && sink_last && !drop_now && !desc_full;
        rewind      = accept && sink_last && !commit;
        sram_csb0   = !wr_en;
        sram_web0   = !wr_en;
        sram_wmask0 = 4'hF;
        sram_addr0  = wr_cur;
        sram_din0   = sink_data;
        level       = used;
    end

    // Write pointer, commit pointer, drop flag and in-progress length
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_cur    <= '0;
            wr_commit <= '0;
            drop      <= 1'b0;
            pkt_len   <= '0;
        end else if (accept) begin
            if (commit) begin
                wr_cur    <= ptr_inc(wr_cur);
                wr_commit <= ptr_inc(wr_cur);
                pkt_len   <= '0;
                drop      <= 1'b0;
            end else if (rewind) begin
                wr_cur    <= wr_commit;
                pkt_len   <= '0;
                drop      <= 1'b0;
            end else if (wr_en) begin
                wr_cur    <= ptr_inc(wr_cur);
                pkt_len   <= pkt_len + LW'(1);
            end else begin
                drop      <= 1'b1;
            end
        end
    end

    // Full flag: separates used==DEPTH from used==0 when wr_cur==rd_ptr
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            full <= 1'b0;
        else if (rewind)
            full <= full && (pkt_len == '0) && !issue;
        else if (issue)
            full <= 1'b0;
        else if (wr_en)
            full <= (ptr_inc(wr_cur) == rd_ptr);
    end

    // Descriptor FIFO pointers; push on commit, release on last accept
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            desc_wr  <= '0;
            desc_rd  <= '0;
            desc_cnt <= '0;
        end else begin
            if (commit)
                desc_wr <= desc_wr + DW'(1);
            if (last_accept)
                desc_rd <= desc_rd + DW'(1);
            desc_cnt <= desc_cnt + (DW+1)'(commit) - (DW+1)'(last_accept);
        end
    end

    // Read FSM state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Read FSM next state, descriptor take and read-issue decision
    always_comb begin
        state_nxt    = state;
        take         = 1'b0;
        take_idx     = desc_rd;
        rem_eff      = remaining;
        be_eff       = act_be;
        be_tag       = 4'hF;
        source_valid = (skid_cnt != 2'd0);
        pop          = source_valid && source_ready;
        last_accept  = pop && skid_last_p1[skid_head];
        occ          = skid_cnt + {1'b0, vld_p0} - {1'b0, pop};
        if (state == IDLE) begin
            take = (desc_cnt != '0);
        end else if (last_accept) begin
            take_idx = desc_rd + DW'(1);
            take     = (desc_cnt > (DW+1)'(1));
        end
        if (take) begin
            rem_eff   = desc_len[take_idx];
            be_eff    = desc_be[take_idx];
            state_nxt = STREAM;
        end else if (last_accept) begin
            state_nxt = IDLE;
        end
        issue = !sys_rst && (rem_eff != '0) && (occ < 2'd2);
        if (rem_eff == LW'(1))
            be_tag = be_eff;
    end

    assign sram_csb1   = !issue;
    assign sram_addr1  = rd_ptr;
    assign source_data = skid_data_p1[skid_head];
    assign source_last = source_valid && skid_last_p1[skid_head];
    assign source_be   = source_valid ? skid_be_p1[skid_head] : 4'h0;

    // Read pointer, remaining count, in-flight flag and skid occupancy
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            remaining <= '0;
            rd_ptr    <= '0;
            vld_p0    <= 1'b0;
            skid_cnt  <= 2'd0;
            skid_head <= 1'b0;
            skid_tail <= 1'b0;
        end else begin
            remaining <= rem_eff - LW'(issue);
            vld_p0    <= issue;
            if (issue)
                rd_ptr <= ptr_inc(rd_ptr);
            if (vld_p0)
                skid_tail <= ~skid_tail;
            if (pop)
                skid_head <= ~skid_head;
            skid_cnt <= skid_cnt + {1'b0, vld_p0} - {1'b0, pop};
        end
    end

    // Datapath: descriptor storage, read tags (p0) and skid capture (p1)
    always_ff @(posedge sys_clk) begin
        if (commit) begin
            desc_len[desc_wr] <= pkt_len + LW'(1);
            desc_be[desc_wr]  <= sink_be;
        end
        if (take)
            act_be <= be_eff;
        last_p0 <= (rem_eff == LW'(1));
        be_p0   <= be_tag;
        if (vld_p0) begin
            skid_data_p1[skid_tail] <= sram_dout1;
            skid_last_p1[skid_tail] <= last_p0;
            skid_be_p1[skid_tail]   <= be_p0;
        end
    end

`ifdef LITEETH_SRAM_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Packet statistics: commits wrap, drops saturate
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            drop_count <= 16'd0;
            pkt_count  <= 16'd0;
        end else begin
            if (commit)
                pkt_count <= pkt_count + 16'd1;
            if (rewind)
                drop_count <= sat_inc16(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_liteeth_sram_pkt_ctrl.sv
// Bench for liteeth_sram_pkt_ctrl: SRAM model, packet-level scoreboard and
// directed scenarios (latency, wrap, drops, FIFO full, stalls, reset).
module tb_liteeth_sram_pkt_ctrl;
    localparam int AW    = 9;
    localparam int DEPTH = 384;
    localparam int NDESC = 8;

    logic          sys_clk, sys_rst;
    logic          sink_valid, sink_ready, sink_last;
    logic [31:0]   sink_data;
    logic [3:0]    sink_be;
    logic          source_valid, source_ready, source_last;
    logic [31:0]   source_data;
    logic [3:0]    source_be;
    logic          sram_csb0, sram_web0, sram_csb1;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [31:0]   sram_din0, sram_dout1;
    logic [AW:0]   level;
`ifdef LITEETH_SRAM_CTRL_STATS_EN
    logic [15:0]   drop_count, pkt_count;
`endif

    liteeth_sram_pkt_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DESC_DEPTH(NDESC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_data(sink_data),
        .sink_last(sink_last), .sink_be(sink_be),
        .source_valid(source_valid), .source_ready(source_ready), .source_data(source_data),
        .source_last(source_last), .source_be(source_be),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
`ifdef LITEETH_SRAM_CTRL_STATS_EN
        .drop_count(drop_count), .pkt_count(pkt_count),
`endif
        .level(level)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // SRAM model: port 0 write, port 1 registered read
    logic [31:0] mem [0:DEPTH-1];
    int          last_wr_addr = -1;
    bit          wrap_seen = 0;
    always @(posedge sys_clk) begin
        if (!sram_csb0 && !sram_web0) begin
            mem[sram_addr0] <= sram_din0;
            if (last_wr_addr == DEPTH-1 && sram_addr0 == '0) wrap_seen = 1;
            last_wr_addr = int'(sram_addr0);
        end
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    int n_cmp = 0, n_err = 0, n_deliv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Packet-level model: committed packets queue up word by word; a packet
    // is kept only if it fits beside undelivered words and fewer than
    // NDESC packets are outstanding.
    typedef struct { logic [31:0] data; logic last; logic [3:0] be; } exp_t;
    exp_t exp_q[$];
    int   pend_words = 0, pend_pkts = 0;

    // Output checker: every valid beat against the model, stall stability
    bit          stalled = 0;
    logic [31:0] stall_data;
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            stalled = 0;
        end else begin
            if (!sram_csb0 && !sram_csb1)
                chk("port_addr_distinct", 64'(sram_addr0 != sram_addr1), 64'd1);
            if (!sram_csb0)
                chk("wmask", 64'(sram_wmask0), 64'hF);
            if (stalled)
                chk("valid_held", 64'(source_valid), 64'd1);
            if (source_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_word: actual %h required none", source_data);
                end else begin
                    chk("src_data", 64'(source_data), 64'(exp_q[0].data));
                    chk("src_last", 64'(source_last), 64'(exp_q[0].last));
                    chk("src_be",   64'(source_be),   64'(exp_q[0].be));
                end
                if (stalled) chk("stall_stable", 64'(source_data), 64'(stall_data));
                if (source_ready) begin
                    if (exp_q.size() != 0) begin
                        if (exp_q[0].last) pend_pkts--;
                        pend_words--;
                        void'(exp_q.pop_front());
                    end
                    n_deliv++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    stall_data = source_data;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic drive_word(input logic [31:0] d, input logic last, input logic [3:0] be);
        sink_valid = 1'b1; sink_data = d; sink_last = last; sink_be = be;
        @(posedge sys_clk); #1;
        sink_valid = 1'b0; sink_last = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [31:0] base, input logic [3:0] be);
        bit   keep;
        exp_t e;
        keep = (len <= DEPTH - pend_words) && (pend_pkts < NDESC);
        for (int i = 0; i < len; i++) drive_word(base + 32'(i), (i == len-1), be);
        if (keep) begin
            pend_words += len;
            pend_pkts++;
            for (int i = 0; i < len; i++) begin
                e.data = base + 32'(i);
                e.last = (i == len-1);
                e.be   = (i == len-1) ? be : 4'hF;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || source_valid || level != '0) && k < 3000) begin
            @(posedge sys_clk); #1; k++;
        end
        if (k >= 3000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: actual %0d words left required 0", name, exp_q.size());
        end
        chk({name, "_level"}, 64'(level), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sink_ready"},   64'(sink_ready),   64'd0);
        chk({tag, "_csb0"},         64'(sram_csb0),    64'd1);
        chk({tag, "_web0"},         64'(sram_web0),    64'd1);
        chk({tag, "_csb1"},         64'(sram_csb1),    64'd1);
        chk({tag, "_source_valid"}, 64'(source_valid), 64'd0);
        chk({tag, "_source_last"},  64'(source_last),  64'd0);
        chk({tag, "_source_be"},    64'(source_be),    64'd0);
        chk({tag, "_level"},        64'(level),        64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        sys_rst = 1'b1; sink_valid = 1'b0; sink_last = 1'b0; sink_data = '0; sink_be = '0;
        source_ready = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check_reset_outputs("rst");
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // 4-word packet, first valid 3 cycles after the last-word cycle
        send_pkt(4, 32'h1000_0000, 4'h3);
        chk("lat_c1_valid", 64'(source_valid), 64'd0);
        @(posedge sys_clk); #1;
        chk("lat_c2_valid", 64'(source_valid), 64'd0);
        @(posedge sys_clk); #1;
        chk("lat_c3_valid", 64'(source_valid), 64'd1);
        chk("lat_c3_data",  64'(source_data),  64'h1000_0000);
        for (int k = 0; k < 10 && !(source_valid && source_last); k++) begin
            @(posedge sys_clk); #1;
        end
        chk("pkt1_last_be",   64'(source_be),   64'h3);
        chk("pkt1_last_data", 64'(source_data), 64'h1000_0003);
        wait_drain("pkt1");

        // 380 words then 10 words: write address wraps 383 -> 0
        send_pkt(380, 32'h2000_0000, 4'hF);
        wait_drain("big380");
        send_pkt(10, 32'h2100_0000, 4'h5);
        wait_drain("wrap10");
        chk("wrap_seen", 64'(wrap_seen), 64'd1);

        // 400-word packet cannot fit: dropped, buffer released
        send_pkt(400, 32'h3000_0000, 4'hF);
        chk("drop400_level", 64'(level), 64'd0);
        repeat (6) @(posedge sys_clk);
        #1;
`ifdef LITEETH_SRAM_CTRL_STATS_EN
        chk("drop_count", 64'(drop_count), 64'd1);
`endif
        send_pkt(2, 32'h3100_0000, 4'h1);
        wait_drain("after_drop");

        // Exactly DEPTH words fill the buffer and still commit
        send_pkt(DEPTH, 32'h4000_0000, 4'h7);
        chk("full_level", 64'(level), 64'd384);
        wait_drain("full384");

        // Nine one-word packets while stalled: only eight descriptors fit
        source_ready = 1'b0;
        d0 = n_deliv;
        for (int k = 0; k < 9; k++) send_pkt(1, 32'h5000_0000 + 32'(k) * 32'h10, 4'h1);
        repeat (5) @(posedge sys_clk);
        #1;
        chk("stalled_valid", 64'(source_valid), 64'd1);
        source_ready = 1'b1;
        wait_drain("desc_full");
        chk("desc_full_delivered", 64'(n_deliv - d0), 64'd8);

        // Back-to-back packets under random source_ready
        d0 = n_deliv;
        fork
            begin
                send_pkt(5, 32'h6000_0000, 4'h7);
                send_pkt(1, 32'h6100_0000, 4'h8);
                send_pkt(7, 32'h6200_0000, 4'hC);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    source_ready = 1'($urandom_range(0, 1));
                    @(posedge sys_clk); #1;
                end
            end
        join
        source_ready = 1'b1;
        wait_drain("random_ready");
        chk("random_delivered", 64'(n_deliv - d0), 64'd13);

        // Reset mid-packet with a committed packet stalled at the output
        source_ready = 1'b0;
        send_pkt(2, 32'h7000_0000, 4'hF);
        repeat (4) @(posedge sys_clk);
        #1;
        for (int k = 0; k < 3; k++) drive_word(32'h7050_0000 + 32'(k), 1'b0, 4'hF);
        sys_rst = 1'b1;
        exp_q.delete();
        pend_words = 0;
        pend_pkts  = 0;
        @(posedge sys_clk); #1;
        check_reset_outputs("midrst");
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        source_ready = 1'b1;
        d0 = n_deliv;
        send_pkt(2, 32'h7100_0000, 4'h1);
        wait_drain("post_reset");
        chk("post_reset_delivered", 64'(n_deliv - d0), 64'd2);
        chk("words_outstanding", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
